// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and elaboration helpers for the FIFO read-side stream controller.
package fifo_stream_reader_pkg;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    // Smallest width w such that 2**w >= value (0 for value <= 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) begin
            width = width + 1;
        end
        return width;
    endfunction

    // FIFO read latency the in-flight tracker is built for.
    function automatic bit rd_latency_legal(input int unsigned rd_latency);
        return (rd_latency >= 1) && (rd_latency <= 4);
    endfunction

    // Output buffer needs at least two entries to hold a word while another lands.
    function automatic bit buf_depth_legal(input int unsigned buf_depth);
        return buf_depth >= 2;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_buf.sv
// Circular output buffer: push at tail, pop at head, any depth >= 2.
module stream_out_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BUF_DEPTH  = 3
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             push_i,
    input  logic [DATA_WIDTH-1:0]            push_data_i,
    input  logic                             pop_i,
    output logic [clog2(BUF_DEPTH+1)-1:0]    count_o,
    output logic [DATA_WIDTH-1:0]            head_o
);

    localparam int unsigned PTR_W = clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = clog2(BUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  do_pop_c;

    // Pointer increment with wrap at BUF_DEPTH-1 (depth need not be a power of two).
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign do_pop_c = pop_i && (count_q != '0);

    // Storage, pointers and occupancy; push and pop in one cycle keep the count.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop_c) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({push_i, do_pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;
    // Head is blanked while empty so discarded words never reach the stream.
    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

    // Issue credits guarantee a free slot for every returning word.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (reset_i)
        !(push_i && !do_pop_c && (count_q == CNT_W'(BUF_DEPTH))));

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads words from a fixed-latency synchronous FIFO and presents them as a valid/ready stream.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned BUF_DEPTH  = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_r_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_ready_i,
    output logic                  idle_o
);

    localparam int unsigned INF_W = clog2(RD_LATENCY + 1);
    localparam int unsigned CNT_W = clog2(BUF_DEPTH + 1);
    localparam int unsigned SUM_W = clog2(BUF_DEPTH + RD_LATENCY + 1);

    if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
        $error("fifo_stream_reader: RD_LATENCY must be within 1..4");
    end
    if (!buf_depth_legal(BUF_DEPTH)) begin : g_bad_depth
        $error("fifo_stream_reader: BUF_DEPTH must be at least 2");
    end

    rd_state_e             state_q;
    rd_state_e             state_d;
    logic [RD_LATENCY-1:0] inflight_q;
    logic [INF_W-1:0]      inflight_cnt_c;
    logic [CNT_W-1:0]      buf_count;
    logic [SUM_W-1:0]      occupancy_c;
    logic                  push_c;
    logic                  pop_c;

    // Words already requested but not yet landed in the buffer.
    always_comb begin
        inflight_cnt_c = '0;
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            inflight_cnt_c = inflight_cnt_c + INF_W'(inflight_q[i]);
        end
    end

    // A read is only issued when a buffer slot is guaranteed for its data.
    assign occupancy_c = SUM_W'(buf_count) + SUM_W'(inflight_cnt_c);
    assign fifo_r_en_o = !reset_i && enable_i && !fifo_empty_i
                         && (occupancy_c < SUM_W'(BUF_DEPTH));

    // One bit per outstanding read; the top bit marks data present on fifo_data_i.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= (inflight_q << 1) | RD_LATENCY'(fifo_r_en_o);
        end
    end

    assign push_c = inflight_q[RD_LATENCY-1];
    assign pop_c  = m_valid_o && m_ready_i;

    stream_out_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_out_buf (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (push_c),
        .push_data_i (fifo_data_i),
        .pop_i       (pop_c),
        .count_o     (buf_count),
        .head_o      (m_data_o)
    );

    assign m_valid_o = (buf_count != '0);

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: DRAIN lets outstanding words finish before returning to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!enable_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (enable_i) begin
                    state_d = ST_RUN;
                end else if ((inflight_cnt_c == '0) && (buf_count == '0)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign idle_o = (state_q == ST_IDLE);

endmodule
